ycc_to_rgb_mac: RTL

Sequential YCbCr→RGB converter for the imager color path: the inverse of the RGB→YCbCr dot-product stage. It accepts one YCbCr pixel over a valid/ready handshake and applies a programmable 3×3 signed fixed-point matrix through a single time-shared multiplier. It presents rounded, clamped RGB over a second valid/ready handshake. It is intended for low-rate paths (preview, readback, register-driven test pixels) where area beats throughput.

---
 rtl/ycc_to_rgb_mac_pkg.sv | 22 ++
 rtl/ycc_to_rgb_mac_step.sv | 57 +++++
 rtl/ycc_to_rgb_mac.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ycc_to_rgb_mac_pkg.sv
// Shared imager color-path definitions: converter FSM encoding, step counter
// sizing and the BT.601 YCbCr->RGB coefficient set at FRAC_BITS=6.
package ycc_to_rgb_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int STEP_W    = 4;
    localparam int STEP_LAST = 8;

    localparam int BT601_FRAC_BITS = 6;
    // Packed c22..c00 (c00 in LSBs): 64,0,90 / 64,-22,-46 / 64,113,0
    localparam logic [89:0] BT601_COEF = {
        10'h000, 10'h071, 10'h040,
        10'h3D2, 10'h3EA, 10'h040,
        10'h05A, 10'h000, 10'h040
    };

endpackage

// File: rtl/ycc_to_rgb_mac_step.sv
// One multiply-accumulate step of the matrix: signed operand x signed coefficient
// into a guarded accumulator, with round/shift/clamp of the row total on `last`.
module ycc_mac_step #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 10,
    parameter int FRAC_BITS  = 6
) (
    input  logic                         clk,
    input  logic                         resetb,
    input  logic                         en,
    input  logic                         clear,
    input  logic                         last,
    input  logic signed [DATA_WIDTH:0]   operand,
    input  logic signed [COEF_WIDTH-1:0] coef,
    output logic [DATA_WIDTH-1:0]        result,
    output logic                         result_valid
);

    localparam int PROD_W  = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int ACC_W   = PROD_W + 2;
    localparam int HALF_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic signed [ACC_W-1:0] HALF = (FRAC_BITS > 0) ? (ACC_W'(1) << HALF_SH) : '0;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_WIDTH) - 1);

    function automatic logic [DATA_WIDTH-1:0] round_clamp(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] t;
        begin
            t = (v + HALF) >>> FRAC_BITS;
            if (t < 0)
                round_clamp = '0;
            else if (t > MAXV)
                round_clamp = '1;
            else
                round_clamp = t[DATA_WIDTH-1:0];
        end
    endfunction

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;

    // The product goes straight into the accumulator; the row total is
    // rounded from acc_nxt so the result is ready on the col-2 edge itself.
    assign prod    = PROD_W'(operand) * PROD_W'(coef);
    assign acc_nxt = (clear ? '0 : acc) + ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (!resetb)
            acc <= '0;
        else if (en)
            acc <= acc_nxt;
    end

    assign result       = round_clamp(acc_nxt);
    assign result_valid = en & last;

endmodule

// File: rtl/ycc_to_rgb_mac.sv
// Sequential YCbCr->RGB converter: latches one pixel plus its matrix, runs nine
// time-shared MAC steps, then holds the clamped RGB until downstream accepts it.
module ycc_to_rgb_mac
    import ycc_to_rgb_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 10,
    parameter int FRAC_BITS  = 6
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic [9*COEF_WIDTH-1:0] coef,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   y,
    input  logic [DATA_WIDTH-1:0]   cb,
    input  logic [DATA_WIDTH-1:0]   cr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   r,
    output logic [DATA_WIDTH-1:0]   g,
    output logic [DATA_WIDTH-1:0]   b
);

    localparam int OP_W = DATA_WIDTH + 1;
    localparam int MID  = 1 << (DATA_WIDTH - 1);

    state_t                      state, state_nxt;
    logic [STEP_W-1:0]           step, step_nxt;
    logic signed [OP_W-1:0]      y_q, cb_q, cr_q;
    logic [9*COEF_WIDTH-1:0]     coef_q;
    logic                        in_fire;
    logic                        mac_en;
    logic [1:0]                  col, row;
    logic signed [OP_W-1:0]      operand;
    logic signed [COEF_WIDTH-1:0] coef_sel;
    logic [DATA_WIDTH-1:0]       row_res;
    logic                        row_done;

    assign in_ready  = resetb & enable & ((state == ST_IDLE) | ((state == ST_HOLD) & out_ready));
    assign in_fire   = in_valid & in_ready;
    assign out_valid = (state == ST_HOLD);
    assign mac_en    = (state == ST_MAC);
    assign col       = 2'(step % STEP_W'(3));
    assign row       = 2'(step / STEP_W'(3));

    always_comb begin
        case (col)
            2'd0:    operand = y_q;
            2'd1:    operand = cb_q;
            default: operand = cr_q;
        endcase
    end

    // Row-major packing makes the coefficient index equal to the step number.
    assign coef_sel = coef_q[step*COEF_WIDTH +: COEF_WIDTH];

    always_ff @(posedge clk) begin
        if (in_fire) begin
            y_q    <= {1'b0, y};
            cb_q   <= {1'b0, cb} - OP_W'(MID);
            cr_q   <= {1'b0, cr} - OP_W'(MID);
            coef_q <= coef;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = '0;
        case (state)
            ST_IDLE: if (in_fire) state_nxt = ST_MAC;
            ST_MAC: begin
                if (step == STEP_W'(STEP_LAST))
                    state_nxt = ST_HOLD;
                else
                    step_nxt = step + STEP_W'(1);
            end
            ST_HOLD: if (out_ready) state_nxt = in_fire ? ST_MAC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    ycc_mac_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .clk          (clk),
        .resetb       (resetb),
        .en           (mac_en),
        .clear        (col == 2'd0),
        .last         (col == 2'd2),
        .operand      (operand),
        .coef         (coef_sel),
        .result       (row_res),
        .result_valid (row_done)
    );

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else if (row_done) begin
            case (row)
                2'd0:    r <= row_res;
                2'd1:    g <= row_res;
                default: b <= row_res;
            endcase
        end
    end

endmodule
